// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared 8-bit crypto data bus (nodes 0-3).
// Latency: request-to-grant is one cycle from IDLE; every output is registered.
// Flow control: none; req is level-sensitive and a node keeps grant until last, a timeout or dropping req.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   req[3:0]            per-node request (bit i = node i)
//   last[3:0]           per-node last-packet flag; only the owner's bit matters
//   bus_valid           shared valid; counts as high only when exactly 1'b1
//   bus_data[7:0]       shared data; header source field is [5:4]
//   grant[3:0]          one-hot grant
//   grant_id[1:0]       current or most recent owner
//   busy                owner holds the bus (GRANT or ACTIVE)
//   timeout_err         one-cycle pulse on start or idle timeout
//   hdr_err             one-cycle pulse when the header source differs from grant_id
module bus_arbiter #(
   parameter int START_TIMEOUT = 16,
   parameter int IDLE_TIMEOUT  = 8,
   parameter int GAP_CYCLES    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] last,
   input  logic       bus_valid,
   input  logic [7:0] bus_data,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout_err,
   output logic       hdr_err
);

   typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, GAP} state_t;

   localparam logic [7:0] START_LIM = 8'(START_TIMEOUT - 1);
   localparam logic [7:0] IDLE_LIM  = 8'(IDLE_TIMEOUT - 1);
   localparam logic [7:0] GAP_LIM   = 8'(GAP_CYCLES - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx, cnt_inc;
   logic [1:0] rr_ptr, rr_ptr_nx;
   logic [1:0] grant_id_nx;
   logic [1:0] win_id;
   logic [3:0] grant_nx;
   logic       busy_nx, timeout_nx, hdr_nx;
   logic       vld, hdr_bad, own_last, own_req;

   // Only the source field of the header is inspected.
   logic       unused_data_bits;
   assign unused_data_bits = ^{bus_data[7:6], bus_data[3:0]};

   // A floating or unknown bus_valid must never start or extend a transaction.
   assign vld      = (bus_valid === 1'b1);
   assign hdr_bad  = (bus_data[5:4] != grant_id);
   assign own_last = last[grant_id];
   assign own_req  = req[grant_id];
   assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // First requester at or after rr_ptr, wrapping 3->0.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      found  = 1'b0;
      win_id = rr_ptr;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      rr_ptr_nx   = rr_ptr;
      grant_id_nx = grant_id;
      timeout_nx  = 1'b0;
      hdr_nx      = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nx    = GRANT;
               grant_id_nx = win_id;
               rr_ptr_nx   = win_id + 2'd1;
               cnt_nx      = 8'd0;
            end
         end
         GRANT: begin
            // Header error outranks last, which outranks the timeout.
            if (!own_req) begin
               state_nx = GAP;
               cnt_nx   = 8'd0;
            end else if (vld) begin
               cnt_nx = 8'd0;
               if (hdr_bad) begin
                  hdr_nx   = 1'b1;
                  state_nx = GAP;
               end else if (own_last) begin
                  state_nx = GAP;
               end else begin
                  state_nx = ACTIVE;
               end
            end else if (cnt >= START_LIM) begin
               timeout_nx = 1'b1;
               state_nx   = GAP;
               cnt_nx     = 8'd0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         ACTIVE: begin
            if (vld) begin
               cnt_nx = 8'd0;
               if (own_last) state_nx = GAP;
            end else if (cnt >= IDLE_LIM) begin
               timeout_nx = 1'b1;
               state_nx   = GAP;
               cnt_nx     = 8'd0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         GAP: begin
            if (cnt >= GAP_LIM) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase

      // Outputs are derived from the next state so they line up with it.
      busy_nx  = (state_nx == GRANT) || (state_nx == ACTIVE);
      grant_nx = busy_nx ? (4'b0001 << grant_id_nx) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         rr_ptr      <= 2'd0;
         grant       <= 4'b0000;
         grant_id    <= 2'd0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         hdr_err     <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         rr_ptr      <= rr_ptr_nx;
         grant       <= grant_nx;
         grant_id    <= grant_id_nx;
         busy        <= busy_nx;
         timeout_err <= timeout_nx;
         hdr_err     <= hdr_nx;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized node traffic for bus_arbiter.
// Expected outputs come from a transaction-level owner model updated once per clock edge.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_bus_arbiter;
   localparam int ST = 16;
   localparam int IT = 8;
   localparam int GC = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b1111;
   logic [3:0] last = 4'b0000;
   logic       bus_valid = 1'b0;
   logic [7:0] bus_data = 8'h00;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy, timeout_err, hdr_err;

   int errors = 0;
   int checks = 0;

   bus_arbiter #(.START_TIMEOUT(ST), .IDLE_TIMEOUT(IT), .GAP_CYCLES(GC)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .bus_valid(bus_valid),
      .bus_data(bus_data), .grant(grant), .grant_id(grant_id), .busy(busy),
      .timeout_err(timeout_err), .hdr_err(hdr_err)
   );

   always #5 clk = ~clk;

   // Owner model: who holds the bus, whether its header arrived, how long it has been quiet.
   int m_owner, m_started, m_quiet, m_gap, m_ptr, m_prev;
   logic [3:0] e_grant;
   logic [1:0] e_id;
   logic e_busy, e_to, e_hdr;

   function void model_reset();
      m_owner = -1; m_started = 0; m_quiet = 0; m_gap = 0; m_ptr = 0; m_prev = 0;
      e_grant = 4'b0; e_id = 2'd0; e_busy = 1'b0; e_to = 1'b0; e_hdr = 1'b0;
   endfunction

   function void model_release();
      m_owner = -1;
      m_gap = GC;
   endfunction

   function void model_step();
      bit bv;
      int src, pick;
      bv = (bus_valid === 1'b1);
      src = int'(bus_data[5:4]);
      e_to = 1'b0;
      e_hdr = 1'b0;
      if (m_owner >= 0) begin
         if (m_started == 0) begin
            if (!req[m_owner]) model_release();
            else if (bv) begin
               if (src != m_owner) begin e_hdr = 1'b1; model_release(); end
               else if (last[m_owner]) model_release();
               else begin m_started = 1; m_quiet = 0; end
            end else if (m_quiet + 1 >= ST) begin e_to = 1'b1; model_release(); end
            else m_quiet++;
         end else begin
            if (bv) begin
               if (last[m_owner]) model_release();
               else m_quiet = 0;
            end else if (m_quiet + 1 >= IT) begin e_to = 1'b1; model_release(); end
            else m_quiet++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != 4'b0) begin
         pick = -1;
         for (int k = 0; k < 4; k++)
            if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
         m_owner = pick; m_started = 0; m_quiet = 0;
         m_ptr = (pick + 1) % 4; m_prev = pick;
      end
      e_busy = (m_owner >= 0);
      e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      e_id = 2'(m_prev);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("grant", 32'(grant), 32'(e_grant));
      chk("grant_id", 32'(grant_id), 32'(e_id));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
      chk("hdr_err", 32'(hdr_err), 32'(e_hdr));
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      for (int i = 0; i < 50 && grant == 4'b0; i++) begin cyc(); n++; end
      chk("grant_seen", 32'(grant != 4'b0), 32'd1);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] l);
      bus_valid = v; bus_data = d; last = l;
   endtask

   int n, id, stall;
   logic [3:0] rr_exp [3] = '{4'b0010, 4'b1000, 4'b0010};

   initial begin
      model_reset();
      stall = 0;
      // Reset held with every node requesting.
      @(negedge clk);
      idle(3);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'({timeout_err, hdr_err}), 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("first_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      idle(4);

      // Round robin between nodes 1 and 3, four bytes each.
      req = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         wait_grant(n);
         chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
         if (k > 0) chk("rr_gap", 32'(n), 32'(GC + 1));
         id = int'(grant_id);
         for (int b = 0; b < 4; b++) begin
            drive(1'b1, {2'b00, 2'(id), 4'hB}, (b == 3) ? 4'(1 << id) : 4'b0);
            cyc();
         end
         drive(1'b0, 8'h00, 4'b0);
      end
      req = 4'b0000;
      idle(4);

      // Single-byte transaction from node 2.
      req = 4'b0100;
      wait_grant(n);
      chk("sb_grant", 32'(grant), 32'h4);
      drive(1'b1, 8'h28, 4'b0100);
      cyc();
      chk("sb_release", 32'(grant), 32'h0);
      chk("sb_no_hdr", 32'(hdr_err), 32'h0);
      drive(1'b0, 8'h00, 4'b0);
      req = 4'b0000;
      idle(3);

      // Header mismatch from node 1, node 0 waiting.
      req = 4'b0010;
      wait_grant(n);
      chk("hm_grant", 32'(grant), 32'h2);
      req = 4'b0011;
      drive(1'b1, 8'h30, 4'b0);
      cyc();
      chk("hm_pulse", 32'(hdr_err), 32'h1);
      chk("hm_release", 32'(grant), 32'h0);
      drive(1'b0, 8'h00, 4'b0);
      cyc();
      chk("hm_pulse_end", 32'(hdr_err), 32'h0);
      wait_grant(n);
      chk("hm_next", 32'(grant), 32'h1);
      req = 4'b0000;
      idle(4);

      // Start timeout on node 3.
      req = 4'b1000;
      wait_grant(n);
      chk("st_grant", 32'(grant), 32'h8);
      n = 0;
      for (int i = 0; i < 40 && !timeout_err; i++) begin cyc(); n++; end
      chk("st_delay", 32'(n), 32'(ST));
      chk("st_release", 32'(grant), 32'h0);
      req = 4'b0000;
      idle(3);

      // Idle timeout on node 0: 7 quiet cycles survive, 8 do not.
      req = 4'b0001;
      wait_grant(n);
      drive(1'b1, 8'h05, 4'b0);
      cyc();
      drive(1'b0, 8'h00, 4'b0);
      idle(IT - 1);
      chk("it_7_quiet", 32'(timeout_err), 32'h0);
      chk("it_7_grant", 32'(grant), 32'h1);
      drive(1'b1, 8'h07, 4'b0);
      cyc();
      drive(1'b0, 8'h00, 4'b0);
      idle(IT - 1);
      chk("it_7b_quiet", 32'(timeout_err), 32'h0);
      cyc();
      chk("it_8_pulse", 32'(timeout_err), 32'h1);
      chk("it_8_release", 32'(grant), 32'h0);
      req = 4'b0000;
      idle(3);

      // Asynchronous reset while node 1 is mid-transaction.
      req = 4'b0010;
      wait_grant(n);
      drive(1'b1, 8'h10, 4'b0);
      cyc();
      drive(1'b0, 8'h00, 4'b0);
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_grant", 32'(grant), 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      req = 4'b1010;
      idle(2);
      rst_n = 1'b1;
      cyc();
      chk("ar_restart", 32'(grant), 32'h2);

      // Randomized node traffic.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
         if (stall > 0) begin
            bus_valid = 1'b0; stall--;
         end else if ($urandom_range(0, 40) == 0) begin
            bus_valid = 1'b0; stall = $urandom_range(6, 20);
         end else begin
            bus_valid = ($urandom_range(0, 2) != 0);
         end
         bus_data = 8'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 9) != 0) bus_data[5:4] = 2'(m_owner);
         last = 4'($urandom_range(0, 15));
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) last[m_owner] = 1'b0;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the shared 8-bit crypto data bus. Issues the one-hot bus_grant consumed by up to four data_bus nodes (IDs 0-3).
- Round-robin fairness across requesters.
- Monitors bus_valid, the header byte and the owner's last-packet flag to decide when a transaction ends.
- Forces an idle gap between owners so receivers re-latch the header; recovers from stalled or misbehaving owners via timeouts.

Parameters:
- START_TIMEOUT, 16: max cycles from grant to first bus_valid before revoking (1-255).
- IDLE_TIMEOUT, 8: max consecutive cycles with bus_valid low inside an active transaction (1-255).
- GAP_CYCLES, 1: cycles with all grants low between owners (1-255).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-node bus request; bit i = node ID i; level-sensitive.
- last  input  4  per-node last-packet flag (node's ack); only last[grant_id] is used.
- bus_valid  input  1  shared bus_valid; true only when exactly 1'b1 (z/x/0 = low).
- bus_data  input  8  shared bus_data; header source field is [5:4].
- grant  output  4  one-hot bus grant, registered.
- grant_id  output  2  index of current/last owner.
- busy  output  1  high in GRANT or ACTIVE.
- timeout_err  output  1  one-cycle pulse on start or idle timeout.
- hdr_err  output  1  one-cycle pulse when header source != grant_id.

Behaviour:
- Reset values: grant=0, grant_id=0, busy=0, timeout_err=0, hdr_err=0, rr_ptr=0, state=IDLE, counter=0. Reset mid-transaction drops grant asynchronously; the node releases the bus accordingly.
- All outputs registered. Any decision made in cycle N is visible in cycle N+1.
- Round-robin: search req starting at rr_ptr, ascending with wrap 3->0; first set bit wins. On grant, rr_ptr <= winner+1 mod 4.
- IDLE: if req!=0 -> GRANT; grant[winner]=1, grant_id=winner, counter=0. Otherwise stay.
- GRANT (waiting for header):
  - req[grant_id] low -> GAP (no error).
  - bus_valid high with bus_data[5:4]!=grant_id -> hdr_err pulse, -> GAP.
  - bus_valid high with last[grant_id] -> GAP (single-byte transaction).
  - bus_valid high otherwise -> ACTIVE, counter=0.
  - counter reaching START_TIMEOUT-1 with no bus_valid -> timeout_err pulse, -> GAP.
- ACTIVE:
  - bus_valid high and last[grant_id] -> GAP.
  - bus_valid high without last -> counter=0.
  - bus_valid low -> counter+1; at IDLE_TIMEOUT-1 -> timeout_err pulse, -> GAP.
  - req changes are ignored in ACTIVE.
- GAP: grant=0, busy=0; hold GAP_CYCLES cycles, then -> IDLE. grant_id keeps the previous owner.
- Event priority in the same cycle: header error > last > timeout.
- Counter is 8 bits, saturating; never wraps.
- At most one grant bit set at any time. grant is never asserted in the cycle immediately after a release.
- Minimum request-to-grant latency: 1 cycle from IDLE.
- Back-to-back owners are separated by GAP_CYCLES+1 cycles of no grant (GAP plus the IDLE decision cycle).

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, busy=0, no error pulses. Release reset -> grant=4'b0001 one cycle later.
- Round-robin: req=4'b1010 held, each owner sends header plus 3 bytes with last on byte 4 -> grants alternate 4'b0010, 4'b1000, 4'b0010, with GAP_CYCLES+1 idle-grant cycles between owners.
- Single-byte transaction: node 2 granted, drives bus_valid=1, bus_data=8'h28, last[2]=1 in the same cycle -> grant drops next cycle, no hdr_err.
- Header mismatch: node 1 granted, first byte 8'h30 (source 3) -> hdr_err=1 for exactly one cycle, grant=0 next cycle, then node 0 granted if requesting.
- Start timeout: node 3 granted, bus_valid never high, START_TIMEOUT=16 -> timeout_err pulse 16 cycles after grant rises, grant released. Idle timeout: mid-transaction bus_valid low for 8 cycles -> pulse and release. 7 low cycles followed by a valid byte -> no pulse.
- Async reset mid-ACTIVE: assert rst_n=0 between clock edges -> grant=0 immediately. After release, arbitration restarts from rr_ptr=0.
